// File: rtl/e_mdu_issue_if.sv
// e_mdu_issue_if: pipeline/MD-unit signal bundle for the MDU issue stage
// req, in_sel, in_d1, in_d2 : E-stage flush, MD op code and forwarded rs/rt operands
// in_stall                  : hold request back to the pipeline
// mdu_start/op/a/b          : command to the multi-cycle MD unit; mdu_busy is its busy flag
// issue_busy, wdt_err       : issue FSM not idle, sticky watchdog flag
interface e_mdu_issue_if;
   logic        req;
   logic [3:0]  in_sel;
   logic [31:0] in_d1;
   logic [31:0] in_d2;
   logic        in_stall;
   logic        mdu_start;
   logic [3:0]  mdu_op;
   logic [31:0] mdu_a;
   logic [31:0] mdu_b;
   logic        mdu_busy;
   logic        issue_busy;
   logic        wdt_err;
   modport master (
      output req, in_sel, in_d1, in_d2, mdu_busy,
      input  in_stall, mdu_start, mdu_op, mdu_a, mdu_b, issue_busy, wdt_err
   );
   modport slave (
      input  req, in_sel, in_d1, in_d2, mdu_busy,
      output in_stall, mdu_start, mdu_op, mdu_a, mdu_b, issue_busy, wdt_err
   );
endinterface

// File: rtl/e_mdu_issue.sv
// e_mdu_issue: issues E-stage multiply/divide ops to a multi-cycle MD unit and stalls dependents
// clk, reset : rising-edge clock, synchronous active-high reset
// bus        : e_mdu_issue_if.slave (op/operands in, stall out, MD unit command out, busy in)
// WDT_LIMIT  : WAIT-cycle ceiling for the optional watchdog (build with MDU_ISSUE_WDT_EN)
// op codes   : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
module e_mdu_issue #(
   parameter int WDT_LIMIT = 63
) (
   input logic          clk,
   input logic          reset,
   e_mdu_issue_if.slave bus
);
   localparam logic [3:0] MD_MULT = 4'd1;
   localparam logic [3:0] MD_DIVU = 4'd4;
   localparam logic [3:0] MD_MFHI = 4'd5;
   localparam logic [3:0] MD_MTLO = 4'd8;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_e;
   state_e      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        first_q, first_d;
   logic        start_op, direct_op, wdt_hit;
   assign start_op  = bus.in_sel >= MD_MULT && bus.in_sel <= MD_DIVU;
   assign direct_op = bus.in_sel >= MD_MFHI && bus.in_sel <= MD_MTLO;
   assign bus.issue_busy = state_q != IDLE;
`ifdef MDU_ISSUE_WDT_EN
   logic [5:0] cnt_q;
   logic       wdt_q;
   // counter sits at zero outside WAIT, so it is already clear on WAIT entry
   assign wdt_hit = state_q == WAIT && cnt_q + 6'd1 == 6'(WDT_LIMIT);
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         wdt_q <= 1'b0;
      end else begin
         cnt_q <= state_q == WAIT ? cnt_q + 6'd1 : 6'd0;
         wdt_q <= wdt_q | wdt_hit;
      end
   end
   assign bus.wdt_err = wdt_q;
`else
   assign wdt_hit     = 1'b0;
   assign bus.wdt_err = WDT_LIMIT < 0;
`endif
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      a_d           = a_q;
      b_d           = b_q;
      first_d       = 1'b0;
      bus.mdu_start = 1'b0;
      bus.mdu_op    = op_q;
      bus.mdu_a     = a_q;
      bus.mdu_b     = b_q;
      bus.in_stall  = bus.in_sel != 4'd0;
      case (state_q)
         IDLE: begin
            // a start-class op retires here; its command goes out next cycle
            bus.in_stall = 1'b0;
            bus.mdu_op   = (!bus.req && direct_op) ? bus.in_sel : 4'd0;
            bus.mdu_a    = bus.in_d1;
            bus.mdu_b    = bus.in_d2;
            if (!bus.req && start_op) begin
               state_d = LAUNCH;
               op_d    = bus.in_sel;
               a_d     = bus.in_d1;
               b_d     = bus.in_d2;
            end
         end
         LAUNCH: begin
            bus.mdu_start = !bus.req;
            state_d       = bus.req ? IDLE : WAIT;
            first_d       = !bus.req;
            op_d          = bus.req ? 4'd0 : op_q;
         end
         WAIT: begin
            // mdu_busy only rises the cycle after mdu_start, so the first WAIT cycle is blind
            if (wdt_hit || (!first_q && !bus.mdu_busy)) begin
               state_d = IDLE;
               op_d    = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         first_q <= first_d;
      end
   end
endmodule

// File: doc/e_mdu_issue.md
E_MDU_ISSUE -- requirements
Module: e_mdu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req  in  1  exception/interrupt flush from the M stage.
REQ-004 SHALL have: in_sel  in  4  E-stage MD op, codes per const.v `md_*` (mult, multu, div, divu, mfhi, mflo, mthi, mtlo); 0 = none.
REQ-005 SHALL have: in_d1, in_d2  in  32 each  forwarded rs/rt operands.
REQ-006 SHALL have: in_stall  out  1  hold request to the pipeline (freeze D/E, bubble M).
REQ-007 SHALL have: mdu_start  out  1, mdu_op  out  4, mdu_a  out  32, mdu_b  out  32  command to the multi-cycle MD unit.
REQ-008 SHALL have: mdu_busy  in  1  MD unit busy, raised the cycle after mdu_start, lowered when HI/LO are written.
REQ-009 SHALL have: issue_busy  out  1  state != IDLE; wdt_err  out  1  sticky watchdog flag.
REQ-010 SHALL have parameter: WDT_LIMIT, default 63, WAIT-cycle ceiling (6-bit counter).

Function
REQ-011 SHALL implement FSM states IDLE, LAUNCH, WAIT.
REQ-012 SHALL treat mult/multu/div/divu as start-class ops; mfhi/mflo/mthi/mtlo as direct ops.
REQ-013 In IDLE with start-class in_sel and req=0, SHALL register in_sel/in_d1/in_d2 and go to LAUNCH; in_stall=0 that cycle, so the op retires.
REQ-014 In LAUNCH with req=0, SHALL drive mdu_start=1 for exactly one cycle with the registered op/operands, then go to WAIT.
REQ-015 In LAUNCH with req=1, SHALL drive mdu_start=0, discard the registered op and return to IDLE.
REQ-016 In WAIT, SHALL ignore mdu_busy on the first WAIT cycle, then return to IDLE on the first cycle mdu_busy=0; req SHALL NOT cancel WAIT.
REQ-017 In IDLE with a direct op and req=0, SHALL pass in_sel/in_d1/in_d2 combinationally to mdu_op/mdu_a/mdu_b with mdu_start=0.
REQ-018 In IDLE with req=1, SHALL drive mdu_op=0, mdu_start=0, and accept nothing.
REQ-019 In LAUNCH or WAIT, in_stall SHALL equal (in_sel != 0); non-MD instructions SHALL flow unstalled.
REQ-020 In LAUNCH/WAIT, mdu_op/mdu_a/mdu_b SHALL hold the registered values; mdu_op=0 after WAIT exit.
REQ-021 Back-to-back MD ops: the second SHALL be stalled until the IDLE cycle after WAIT exits, then accepted per REQ-013/REQ-017.
REQ-022 Divide by zero SHALL be launched unchanged (result architecturally undefined); no special handling.

Reset
REQ-023 On reset: state=IDLE, registered op=0, operands=0, WAIT counter=0, wdt_err=0; mdu_start=0, in_stall=0, issue_busy=0.
REQ-024 Reset mid-LAUNCH or mid-WAIT SHALL abandon the op with no mdu_start pulse in the following cycle.

Configuration
REQ-025 Macro MDU_ISSUE_WDT_EN: when defined, a 6-bit counter SHALL clear on WAIT entry, increment each WAIT cycle, and on reaching WDT_LIMIT force IDLE and set wdt_err (sticky until reset).
REQ-026 Without MDU_ISSUE_WDT_EN, no counter SHALL exist, wdt_err SHALL be constant 0, and WAIT ends only per REQ-016.

Verification
REQ-027 mult d1=0xFFFFFFFE, d2=3 in IDLE -> next cycle mdu_start=1, mdu_op=`md_mult`, mdu_a=0xFFFFFFFE, mdu_b=3; issue_busy=1.
REQ-028 mult then mflo one cycle later, MDU busy 5 cycles -> mflo stalled (in_stall=1) through WAIT, accepted on first IDLE cycle with mdu_op=`md_mflo`.
REQ-029 div accepted, req=1 during LAUNCH -> no mdu_start ever, state IDLE next cycle; req=1 during WAIT -> WAIT runs to mdu_busy=0.
REQ-030 mthi d1=0x12345678 in IDLE -> same cycle mdu_op=`md_mthi`, mdu_a=0x12345678, mdu_start=0, in_stall=0.
REQ-031 With MDU_ISSUE_WDT_EN, mdu_busy held 1 forever after divu -> IDLE after 63 WAIT cycles, wdt_err=1 until reset.
REQ-032 Reset asserted in WAIT with addu in E -> next cycle state IDLE, in_stall=0, mdu_start=0.
